dlx_hazard_ctrl: RTL and testbench
==================================

Name: dlx_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage DLX core.
- Tracks destination registers of the instructions in EX, MEM and WB.
- Generates PC/IF-ID enables, ID/EX bubbles, IF/ID flush and registered forwarding selects.
- Sequences the multi-cycle MULT/MULTU unit by freezing the front end until the product is ready.

Parameters:
- MULT_LATENCY, 4, total EX cycles of MULT/MULTU (legal range 2..15).
- REG_ADDR_W, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID instruction is live (low when killed by the previous stage).
- id_rs1_sel  in  5  ID source register 1.
- id_rs2_sel  in  5  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_regwr  in  1  ID instruction writes a register.
- id_rd  in  5  ID destination register.
- id_is_load  in  1  ID instruction is LW/LH/LHU/LB/LBU.
- id_is_mult  in  1  ID instruction is MULT/MULTU.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  replace the IF/ID contents with a NOP.
- idex_bubble  out  1  load a NOP into ID/EX this cycle.
- fwd_a_sel  out  2  EX operand A source: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- fwd_b_sel  out  2  EX operand B source; same encoding as fwd_a_sel.
- mult_busy  out  1  multiplier occupied.
- state  out  2  debug: current FSM state.

Behaviour:
- Reset:
  - FSM goes to RUN; the EX, MEM and WB tracking slots are cleared (regwr=0, load=0, rd=0).
  - Counter = 0; fwd_a_sel = fwd_b_sel = 0; mult_busy = 0.
  - Combinational outputs at reset: pc_en = 1, ifid_en = 1, ifid_flush = 0, idex_bubble = 0.
  - Reset asserted mid-stall or mid-multiply aborts the operation immediately.
- Tracking pipe, every edge:
  - WB slot <- MEM slot; MEM slot <- EX slot.
  - EX slot <- ID fields if id_valid and idex_bubble = 0; otherwise the EX slot takes an empty entry.
- Register 0 never causes a hazard or a forward.
- Hazard test: "hit(x)" = uses_x and regwr and (sel_x == slot rd) and (rd != 0).
- FSM states:
  - RUN = 0: normal flow.
  - LOAD_STALL = 1: one-cycle load-use interlock.
  - MULT_BUSY = 2: front end frozen while the multiplier runs.
- RUN transitions:
  - Load-use: if the EX slot is a load and hit(rs1) or hit(rs2) against it, with id_valid → pc_en = 0, ifid_en = 0, idex_bubble = 1, ifid_flush = 0, next state LOAD_STALL.
  - Otherwise, if id_valid and id_is_mult → counter <- MULT_LATENCY-1, mult_busy <- 1, next state MULT_BUSY. The MULT itself enters EX normally.
  - Otherwise, if id_valid and id_branch_taken → ifid_flush = 1 for this cycle only.
- LOAD_STALL:
  - All enables = 1; return to RUN.
  - A re-check is unnecessary because the load has advanced to MEM and is forwarded with sel = 2.
- MULT_BUSY:
  - pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - Counter decrements each cycle.
  - When the counter reaches 1: mult_busy <- 0, next state RUN.
  - Net front-end freeze is MULT_LATENCY-1 cycles.
- Priority within one cycle: load-use stall > mult start > branch flush.
  - A taken branch coincident with a stall is not flushed; it is re-evaluated when it re-presents in ID.
- Forwarding selects:
  - Registered on the edge at which the ID instruction enters EX (not when idex_bubble = 1; in that case both are cleared to 0).
  - A source matching the EX slot gives sel = 1.
  - A source matching only the MEM slot gives sel = 2.
  - EX beats MEM when both match.
  - A load in the EX slot never yields sel = 1, because the stall prevents it.
- id_valid = 0: no hazard, no mult start, no flush, no forward.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt [31:0]: increments every cycle pc_en = 0.
  - perf_flush_cnt [31:0]: increments every cycle ifid_flush = 1.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- LW r3 then ADD r5,r3,r4 → one cycle with pc_en = 0 and idex_bubble = 1, state LOAD_STALL for 1 cycle; ADD then enters EX with fwd_a_sel = 2, fwd_b_sel = 0.
- ADD r1,r2,r2 then SUB r6,r1,r1 → no stall; fwd_a_sel = fwd_b_sel = 1 in SUB's EX cycle.
- ADD r1 at t, XOR r1 at t+1, then OR r7,r1,r0 → fwd_a_sel = 1 (newest wins), fwd_b_sel = 0 (r0 never forwards).
- MULT with MULT_LATENCY = 4 → mult_busy high 3 cycles, pc_en low 3 cycles, state = 2 for 3 cycles, then RUN.
- Taken BEQZ while the EX slot holds a load feeding the branch's rs1 → stall first with no flush; on re-present, ifid_flush = 1 for 1 cycle.
- rst_n pulsed low during the second MULT_BUSY cycle → outputs return to reset values immediately; pc_en = 1 after release.

Source files
------------

// File: rtl/dlx_hazard_ctrl.sv
// DLX pipeline sequencer: load-use interlock, multi-cycle MULT freeze, branch flush, forwarding selects.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module dlx_hazard_ctrl #(
    parameter int MULT_LATENCY = 4,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_sel,
    input  logic [REG_ADDR_W-1:0] id_rs2_sel,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_regwr,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_load,
    input  logic                  id_is_mult,
    input  logic                  id_branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mult_busy,
    output logic [1:0]            state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_LOAD_STALL = 2'd1;
    localparam logic [1:0] S_MULT_BUSY  = 2'd2;
    localparam logic [3:0] MULT_INIT    = 4'(MULT_LATENCY - 1);

    // The WB stage needs no slot: the register file writes before it reads.
    logic                  ex_regwr;
    logic                  ex_load;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_regwr;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic [3:0] mult_cnt;
    logic [1:0] next_state;
    logic       mult_start;
    logic       load_use;
    logic       id_enters_ex;

    function automatic logic hit(input logic uses, input logic [REG_ADDR_W-1:0] sel,
                                 input logic regwr, input logic [REG_ADDR_W-1:0] rd);
        return uses && regwr && (sel == rd) && (rd != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_ADDR_W-1:0] sel);
        if (hit(uses, sel, ex_regwr, ex_rd))
            return 2'd1;
        else if (hit(uses, sel, mem_regwr, mem_rd))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign load_use = id_valid && ex_load &&
                      (hit(id_uses_rs1, id_rs1_sel, ex_regwr, ex_rd) ||
                       hit(id_uses_rs2, id_rs2_sel, ex_regwr, ex_rd));

    assign id_enters_ex = id_valid && !idex_bubble;

    // After a load stall the EX slot holds the bubble, so load_use cannot fire there and
    // the released instruction may still start a MULT or flush as a taken branch.
    always_comb begin
        next_state  = state;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mult_start  = 1'b0;
        case (state)
            S_RUN, S_LOAD_STALL: begin
                if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    next_state  = S_LOAD_STALL;
                end else if (id_valid && id_is_mult) begin
                    mult_start = 1'b1;
                    next_state = S_MULT_BUSY;
                end else begin
                    next_state = S_RUN;
                    if (id_valid && id_branch_taken)
                        ifid_flush = 1'b1;
                end
            end
            S_MULT_BUSY: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                if (mult_cnt == 4'd1)
                    next_state = S_RUN;
            end
            default: next_state = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            mult_cnt  <= 4'd0;
            mult_busy <= 1'b0;
        end else begin
            state <= next_state;
            if (mult_start) begin
                mult_cnt  <= MULT_INIT;
                mult_busy <= 1'b1;
            end else if (state == S_MULT_BUSY) begin
                mult_cnt <= mult_cnt - 4'd1;
                if (mult_cnt == 4'd1)
                    mult_busy <= 1'b0;
            end
        end
    end

    // Selects are captured as the ID instruction moves into EX, against the slots it will trail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_regwr  <= 1'b0;
            ex_load   <= 1'b0;
            ex_rd     <= '0;
            mem_regwr <= 1'b0;
            mem_rd    <= '0;
            fwd_a_sel <= 2'd0;
            fwd_b_sel <= 2'd0;
        end else begin
            mem_regwr <= ex_regwr;
            mem_rd    <= ex_rd;
            ex_regwr  <= id_enters_ex && id_regwr;
            ex_load   <= id_enters_ex && id_is_load;
            ex_rd     <= id_enters_ex ? id_rd : '0;
            if (id_enters_ex) begin
                fwd_a_sel <= fwd_sel(id_uses_rs1, id_rs1_sel);
                fwd_b_sel <= fwd_sel(id_uses_rs2, id_rs2_sel);
            end else begin
                fwd_a_sel <= 2'd0;
                fwd_b_sel <= 2'd0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (!pc_en)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (ifid_flush)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Scoreboard bench for dlx_hazard_ctrl: driver queues hand-computed expectations, monitor checks each cycle.
module tb_dlx_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwr;
    logic       id_is_load, id_is_mult, id_branch_taken;
    logic [4:0] id_rs1_sel, id_rs2_sel, id_rd;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, mult_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel, state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       wr;
        logic [4:0] rd;
        logic       ld;
        logic       mu;
        logic       br;
    } in_t;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       fl;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       busy;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    dlx_hazard_ctrl #(.MULT_LATENCY(4), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_sel(id_rs1_sel), .id_rs2_sel(id_rs2_sel),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_regwr(id_regwr), .id_rd(id_rd), .id_is_load(id_is_load),
        .id_is_mult(id_is_mult), .id_branch_taken(id_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mult_busy(mult_busy), .state(state)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic in_t ins(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic wr,
                                input logic [4:0] rd, input logic ld, input logic mu,
                                input logic br);
        in_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.wr = wr; r.rd = rd; r.ld = ld; r.mu = mu; r.br = br;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic pc, input logic ifid, input logic fl,
                                    input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                                    input logic busy, input logic [1:0] st);
        exp_t r;
        r.pc = pc; r.ifid = ifid; r.fl = fl; r.bub = bub;
        r.fa = fa; r.fb = fb; r.busy = busy; r.st = st;
        return r;
    endfunction

    // Normal-flow expectation: enables high, no flush or bubble, given forward selects.
    function automatic exp_t run_exp(input logic [1:0] fa, input logic [1:0] fb);
        return mk_exp(1'b1, 1'b1, 1'b0, 1'b0, fa, fb, 1'b0, 2'd0);
    endfunction

    task automatic applyStimulus(input logic rst_v, input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        rst_n           = rst_v;
        id_valid        = i.v;
        id_rs1_sel      = i.rs1;
        id_rs2_sel      = i.rs2;
        id_uses_rs1     = i.u1;
        id_uses_rs2     = i.u2;
        id_regwr        = i.wr;
        id_rd           = i.rd;
        id_is_load      = i.ld;
        id_is_mult      = i.mu;
        id_branch_taken = i.br;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t got;
        got = {pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel, mult_busy, state};
        vec_cnt++;
        if (got !== e) begin
            err_cnt++;
            $display("[TB] FAIL vec%0d {pc,ifid,flush,bub,fa,fb,busy,st} got=%b want=%b",
                     vec_cnt, got, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0)
                checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        in_t nop, lw3, add5, add1, sub6, add1b, xor1, or7, mult8, add11;
        in_t lw12, beqz, jmp, br_dead, mult_dead, mult4, add13;
        nop       = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw3       = ins(1, 10, 0, 1, 0, 1, 3, 1, 0, 0);
        add5      = ins(1, 3, 4, 1, 1, 1, 5, 0, 0, 0);
        add1      = ins(1, 2, 2, 1, 1, 1, 1, 0, 0, 0);
        sub6      = ins(1, 1, 1, 1, 1, 1, 6, 0, 0, 0);
        add1b     = ins(1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
        xor1      = ins(1, 4, 5, 1, 1, 1, 1, 0, 0, 0);
        or7       = ins(1, 1, 0, 1, 1, 1, 7, 0, 0, 0);
        mult8     = ins(1, 9, 10, 1, 1, 1, 8, 0, 1, 0);
        add11     = ins(1, 8, 1, 1, 1, 1, 11, 0, 0, 0);
        lw12      = ins(1, 10, 0, 1, 0, 1, 12, 1, 0, 0);
        beqz      = ins(1, 12, 0, 1, 0, 0, 0, 0, 0, 1);
        jmp       = ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        br_dead   = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mult_dead = ins(0, 2, 3, 1, 1, 1, 4, 0, 1, 0);
        mult4     = ins(1, 2, 3, 1, 1, 1, 4, 0, 1, 0);
        add13     = ins(1, 4, 4, 1, 1, 1, 13, 0, 0, 0);

        {id_valid, id_uses_rs1, id_uses_rs2, id_regwr, id_is_load, id_is_mult, id_branch_taken} = '0;
        {id_rs1_sel, id_rs2_sel, id_rd} = '0;

        // Reset state
        applyStimulus(1'b0, nop, run_exp(0, 0));
        // Load-use: LW r3 ; ADD r5,r3,r4 -> one stall, then MEM forward on A
        applyStimulus(1'b1, lw3,  run_exp(0, 0));
        applyStimulus(1'b1, add5, mk_exp(0, 0, 0, 1, 0, 0, 0, 2'd0));
        applyStimulus(1'b1, add5, mk_exp(1, 1, 0, 0, 0, 0, 0, 2'd1));
        applyStimulus(1'b1, nop,  run_exp(2, 0));
        // ADD r1,r2,r2 ; SUB r6,r1,r1 -> both operands from EX/MEM
        applyStimulus(1'b1, add1, run_exp(0, 0));
        applyStimulus(1'b1, sub6, run_exp(0, 0));
        applyStimulus(1'b1, nop,  run_exp(1, 1));
        // ADD r1 ; XOR r1 ; OR r7,r1,r0 -> newest producer wins, r0 never forwards
        applyStimulus(1'b1, add1b, run_exp(0, 0));
        applyStimulus(1'b1, xor1,  run_exp(0, 0));
        applyStimulus(1'b1, or7,   run_exp(0, 0));
        applyStimulus(1'b1, nop,   run_exp(1, 0));
        // MULT with latency 4 -> three frozen cycles in MULT_BUSY
        applyStimulus(1'b1, mult8, run_exp(0, 0));
        applyStimulus(1'b1, add11, mk_exp(0, 0, 0, 1, 0, 0, 1, 2'd2));
        applyStimulus(1'b1, add11, mk_exp(0, 0, 0, 1, 0, 0, 1, 2'd2));
        applyStimulus(1'b1, add11, mk_exp(0, 0, 0, 1, 0, 0, 1, 2'd2));
        applyStimulus(1'b1, add11, run_exp(0, 0));
        applyStimulus(1'b1, nop,   run_exp(0, 0));
        // Taken BEQZ on a loaded register: stall without flush, then flush on re-present
        applyStimulus(1'b1, lw12, run_exp(0, 0));
        applyStimulus(1'b1, beqz, mk_exp(0, 0, 0, 1, 0, 0, 0, 2'd0));
        applyStimulus(1'b1, beqz, mk_exp(1, 1, 1, 0, 0, 0, 0, 2'd1));
        applyStimulus(1'b1, nop,  run_exp(2, 0));
        // Plain taken jump flushes; killed branch and killed MULT do nothing
        applyStimulus(1'b1, jmp,       mk_exp(1, 1, 1, 0, 0, 0, 0, 2'd0));
        applyStimulus(1'b1, br_dead,   run_exp(0, 0));
        applyStimulus(1'b1, mult_dead, run_exp(0, 0));
        applyStimulus(1'b1, nop,       run_exp(0, 0));
        // Reset during the second MULT_BUSY cycle aborts the multiply at once
        applyStimulus(1'b1, mult4, run_exp(0, 0));
        applyStimulus(1'b1, add13, mk_exp(0, 0, 0, 1, 0, 0, 1, 2'd2));
        applyStimulus(1'b0, add13, run_exp(0, 0));
        applyStimulus(1'b1, add13, run_exp(0, 0));
        applyStimulus(1'b1, nop,   run_exp(0, 0));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            err_cnt++;
            $display("[TB] FAIL drain %0d expectations left unchecked, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
